// File: rtl/dac_ddr_tx.sv
// dac_ddr_tx: buffers A/B sample pairs in a small FIFO and feeds a pair of
// registered DAC words to an external DDR output stage (ODDR/OSERDES).
// Channel A drives the rising-edge phase and channel B the falling-edge phase.
// Streaming waits until the FIFO holds PRIME_LEVEL pairs, then pops one pair
// per clock. Running dry is an underflow: midscale is output and the block
// re-primes.
//
// Optional build macro DAC_DDR_TX_PATTERN_EN adds the test-pattern modes
// selected by cfg_mode (01 midscale, 10 ramp, 11 checkerboard). Without it
// cfg_mode is ignored and only normal streaming exists.
//
// Handshake: a pair is transferred on a clk250 edge exactly when s_valid and
// s_ready are both high. s_valid must not depend on s_ready. s_ready is the
// only output that is combinational from inputs (enable, cfg_mode, rst).
//
// dbg_state exposes the FSM: 0 IDLE, 1 PRIME, 2 RUN.
module dac_ddr_tx #(
    parameter int DATA_WIDTH  = 12,
    parameter int FIFO_DEPTH  = 4,
    parameter int PRIME_LEVEL = 2,
    parameter int TWOS_COMP   = 1
) (
    input  logic                  clk250,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [1:0]            cfg_mode,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data_a,
    input  logic [DATA_WIDTH-1:0] s_data_b,
    output logic [DATA_WIDTH-1:0] dac_d_rise,
    output logic [DATA_WIDTH-1:0] dac_d_fall,
    output logic                  dac_valid,
    output logic                  underflow,
    output logic [15:0]           underflow_cnt,
    output logic [1:0]            dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] PRIME_C = CW'(PRIME_LEVEL);
    localparam logic [CW-1:0] FILL_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [DATA_WIDTH-1:0] MIDSCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                  state;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [CW-1:0]           fill;
    logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [2*DATA_WIDTH-1:0] rd_word;
    logic                    mode_normal;
    logic                    stream_on;
    logic                    push;
    logic                    pop;

    // Two's complement to offset binary is just an MSB flip, which is the
    // same bit as midscale.
    function automatic logic [DATA_WIDTH-1:0] to_dac(input logic [DATA_WIDTH-1:0] x);
        return (TWOS_COMP != 0) ? (x ^ MIDSCALE) : x;
    endfunction

`ifdef DAC_DDR_TX_PATTERN_EN
    // Alternating 1010... pattern with the MSB side starting at 1 for even widths.
    function automatic logic [DATA_WIDTH-1:0] alt_bits();
        logic [DATA_WIDTH-1:0] p;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            p[i] = ((i % 2) == 1);
        end
        return p;
    endfunction

    localparam logic [DATA_WIDTH-1:0] PAT_A = alt_bits();
    localparam logic [DATA_WIDTH-1:0] PAT_B = ~PAT_A;

    logic [DATA_WIDTH-1:0] ramp;
    logic                  chk_phase;

    assign mode_normal = (cfg_mode == 2'b00);
`else
    logic unused_cfg_mode;

    assign unused_cfg_mode = ^cfg_mode;
    assign mode_normal     = 1'b1;
`endif

    assign stream_on = enable && mode_normal;
    assign s_ready   = (fill < DEPTH_C) && stream_on && !rst;
    assign push      = s_valid && s_ready;
    assign pop       = (state == ST_RUN) && (fill != '0) && stream_on;
    assign rd_word   = mem[rd_ptr];
    assign dbg_state = state;

    // Sample storage; push is already gated by reset and full through s_ready.
    always_ff @(posedge clk250) begin
        if (push) begin
            mem[wr_ptr] <= {s_data_a, s_data_b};
        end
    end

    // FIFO pointers and fill count; disabling or leaving normal mode flushes.
    always_ff @(posedge clk250) begin
        if (rst || !stream_on) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fill <= fill + FILL_ONE;
                2'b01:   fill <= fill - FILL_ONE;
                default: fill <= fill;
            endcase
        end
    end

`ifdef DAC_DDR_TX_PATTERN_EN
    // Pattern generators: ramp advances only while it is being shown, and the
    // checkerboard always restarts on the A=1010... phase.
    always_ff @(posedge clk250) begin
        if (rst) begin
            ramp      <= '0;
            chk_phase <= 1'b0;
        end else begin
            if (enable && cfg_mode == 2'b10) begin
                ramp <= ramp + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
            end
            chk_phase <= (enable && cfg_mode == 2'b11) ? ~chk_phase : 1'b0;
        end
    end
`endif

    // Control FSM with registered DAC words, valid and underflow bookkeeping.
    always_ff @(posedge clk250) begin
        if (rst) begin
            state         <= ST_IDLE;
            dac_d_rise    <= MIDSCALE;
            dac_d_fall    <= MIDSCALE;
            dac_valid     <= 1'b0;
            underflow     <= 1'b0;
            underflow_cnt <= 16'd0;
        end else if (!enable) begin
            state      <= ST_IDLE;
            dac_d_rise <= MIDSCALE;
            dac_d_fall <= MIDSCALE;
            dac_valid  <= 1'b0;
        end
`ifdef DAC_DDR_TX_PATTERN_EN
        else if (!mode_normal) begin
            state     <= ST_IDLE;
            dac_valid <= 1'b1;
            case (cfg_mode)
                2'b10: begin
                    dac_d_rise <= ramp;
                    dac_d_fall <= ~ramp;
                end
                2'b11: begin
                    dac_d_rise <= chk_phase ? PAT_B : PAT_A;
                    dac_d_fall <= chk_phase ? PAT_A : PAT_B;
                end
                default: begin
                    dac_d_rise <= MIDSCALE;
                    dac_d_fall <= MIDSCALE;
                end
            endcase
        end
`endif
        else begin
            case (state)
                ST_IDLE: begin
                    state      <= ST_PRIME;
                    dac_d_rise <= MIDSCALE;
                    dac_d_fall <= MIDSCALE;
                    dac_valid  <= 1'b0;
                end
                ST_PRIME: begin
                    if (fill >= PRIME_C) begin
                        state <= ST_RUN;
                    end
                    dac_d_rise <= MIDSCALE;
                    dac_d_fall <= MIDSCALE;
                    dac_valid  <= 1'b0;
                end
                ST_RUN: begin
                    if (fill != '0) begin
                        dac_d_rise <= to_dac(rd_word[2*DATA_WIDTH-1:DATA_WIDTH]);
                        dac_d_fall <= to_dac(rd_word[DATA_WIDTH-1:0]);
                        dac_valid  <= 1'b1;
                    end else begin
                        state      <= ST_PRIME;
                        dac_d_rise <= MIDSCALE;
                        dac_d_fall <= MIDSCALE;
                        dac_valid  <= 1'b0;
                        underflow  <= 1'b1;
                        if (underflow_cnt != 16'hFFFF) begin
                            underflow_cnt <= underflow_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dac_ddr_tx.md
DAC_DDR_TX -- requirements
Module: dac_ddr_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 12: sample width per channel.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, a power of two ≥ 4: sample-pair buffer depth.
REQ-003 The block SHALL have parameter PRIME_LEVEL, default 2, where 1 ≤ PRIME_LEVEL ≤ FIFO_DEPTH: fill level required to start streaming.
REQ-004 The block SHALL have parameter TWOS_COMP, default 1: 1 means input is two's complement and the MSB is inverted to give offset binary; 0 means input passes unchanged.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset. The ports SHALL be:
  clk250  in  1  250 MHz system clock (BUFG domain)
  rst  in  1  synchronous active-high reset
  enable  in  1  streaming enable
  cfg_mode  in  2  00 normal, 01 midscale, 10 ramp, 11 checkerboard
  s_valid  in  1  input pair valid
  s_ready  out  1  input pair accepted when s_valid && s_ready
  s_data_a  in  DATA_WIDTH  channel A sample
  s_data_b  in  DATA_WIDTH  channel B sample
  dac_d_rise  out  DATA_WIDTH  channel A word for rising-edge phase of external ODDR/OSERDES
  dac_d_fall  out  DATA_WIDTH  channel B word for falling-edge phase
  dac_valid  out  1  output register holds a real sample or pattern
  underflow  out  1  sticky underflow flag
  underflow_cnt  out  16  saturating underflow counter

Function
REQ-006 All outputs SHALL be registered on clk250; nothing SHALL be combinational from input to output except s_ready.
REQ-007 The FSM SHALL have states IDLE, PRIME, and RUN.
REQ-008 IDLE SHALL go to PRIME when enable=1 and the effective mode is 00; in every other case the FSM SHALL stay in IDLE.
REQ-009 PRIME SHALL go to RUN on the edge where the registered fill count is ≥ PRIME_LEVEL.
REQ-010 RUN SHALL pop one FIFO entry on every edge where the fill count is nonzero, loading dac_d_rise/dac_d_fall with the format-converted A/B samples and setting dac_valid=1.
REQ-011 RUN with an empty FIFO at an edge SHALL be an underflow: outputs load midscale, dac_valid=0, underflow is set, underflow_cnt increments and saturates at 0xFFFF, and the FSM goes to PRIME.
REQ-012 With back-to-back input from an empty FIFO and PRIME_LEVEL=2, the first accepted pair SHALL appear on the outputs after the 4th edge counted from its acceptance edge (acceptance edge = edge 0; visible after edge 3).
REQ-013 s_ready SHALL equal (fill count < FIFO_DEPTH) && enable && effective mode == 00 && !rst.
REQ-014 A push and pop on the same edge SHALL leave the fill count unchanged, and data order SHALL be preserved.
REQ-015 A push SHALL never occur while the FIFO is full.
REQ-016 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 Midscale SHALL equal 1 << (DATA_WIDTH-1) (0x800 at width 12) on both outputs, independent of TWOS_COMP.
REQ-018 enable=0 on any edge SHALL flush the FIFO (fill count 0), move the FSM to IDLE, drive outputs to midscale, and set dac_valid=0.
REQ-019 underflow and underflow_cnt SHALL be retained when enable=0.
REQ-020 Format conversion SHALL be bitwise only (MSB inversion when TWOS_COMP=1), with no arithmetic and no saturation.

Reset
REQ-021 rst=1 SHALL have priority over all other inputs.
REQ-022 On rst=1 the block SHALL set FSM=IDLE, fill count 0, read/write pointers 0, dac_d_rise=dac_d_fall=midscale, dac_valid=0, underflow=0, underflow_cnt=0, and the ramp counter to 0.
REQ-023 Reset asserted mid-RUN SHALL discard buffered samples, and no stale sample SHALL appear after reset release.
REQ-024 s_ready SHALL be 0 during rst=1 and on the first edge after release until FSM/enable conditions are met.

Configuration
REQ-025 Macro DAC_DDR_TX_PATTERN_EN defined: cfg_mode 01/10/11 SHALL be active whenever enable=1.
REQ-026 With DAC_DDR_TX_PATTERN_EN defined, any non-00 mode SHALL force FSM=IDLE, flush the FIFO, and set dac_valid=1.
REQ-027 With DAC_DDR_TX_PATTERN_EN defined, mode 01 SHALL output midscale on both words.
REQ-028 With DAC_DDR_TX_PATTERN_EN defined, mode 10 SHALL output ramp counter R on A and ~R on B, where R increments by 1 each edge and wraps from all-ones to 0.
REQ-029 With DAC_DDR_TX_PATTERN_EN defined, mode 11 SHALL output 0xAAA/0x555 on A/B, alternating to 0x555/0xAAA each edge (DATA_WIDTH-bit alternating patterns), starting 0xAAA on A.
REQ-030 With DAC_DDR_TX_PATTERN_EN defined, no pattern mode SHALL touch the underflow flag or counter.
REQ-031 Macro DAC_DDR_TX_PATTERN_EN undefined: cfg_mode SHALL be ignored, the effective mode SHALL be 00, and no pattern logic or ramp counter SHALL exist.

Verification
REQ-032 Reset, then enable=1 with pairs (0x001,0x7FF),(0x002,0x800),(0x003,0xFFF) back-to-back and TWOS_COMP=1 -> the bench SHALL see outputs (0x801,0xFFF),(0x802,0x000),(0x803,0x7FF) on consecutive cycles, the first visible after edge 3.
REQ-033 s_valid held 0 after 3 pairs in RUN -> the bench SHALL see midscale with dac_valid=0 on the 4th output cycle, underflow=1, underflow_cnt=1, and the FSM in PRIME.
REQ-034 s_valid=1 constant with enable=1 and the output side stalled in PRIME (PRIME_LEVEL=FIFO_DEPTH=4) -> the bench SHALL see s_ready drop after 4 accepts and no overwrite, then outputs in order once RUN begins.
REQ-035 rst pulsed for 1 cycle mid-RUN with 3 entries buffered -> the bench SHALL see outputs at midscale, underflow_cnt=0, and the first post-reset output equal to the first post-reset input.
REQ-036 With DAC_DDR_TX_PATTERN_EN defined and cfg_mode=10 for 4100 cycles -> the bench SHALL see A=0,1,…,0xFFF,0,1…, B=~A, and s_ready=0 throughout.
REQ-037 With DAC_DDR_TX_PATTERN_EN defined and cfg_mode=11 -> the bench SHALL see A alternate 0xAAA/0x555 and B the complement each cycle.
